// File: rtl/pool2_pkg.sv
// Shared constants, address-field widths and FSM state type for the pool-2 max-pool stage.
package pool2_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IMG_W     = 8;
  localparam int unsigned POOL_W    = IMG_W / 2;
  localparam int unsigned CHANNELS  = 3;

  localparam int unsigned CH_W      = 2;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned PROW_W    = 2;
  localparam int unsigned RD_ADDR_W = CH_W + 2 * ROW_W;
  localparam int unsigned WR_ADDR_W = CH_W + 2 * PROW_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0   = 3'd1,
    R1   = 3'd2,
    R2   = 3'd3,
    R3   = 3'd4,
    WR   = 3'd5,
    FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/pool2_maxpool_addr_gen.sv
// Window counters (channel, pooled row, pooled column) and conv2/pool-2 address composition.
// rd_addr_c uses the post-advance window while advancing, so the caller can register the
// first read address of the next window in the same cycle the counters step.
module pool2_addr_gen #(
  parameter int unsigned CHANNELS  = pool2_pkg::CHANNELS,
  parameter int unsigned POOL_EDGE = pool2_pkg::POOL_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             advance,
  input  logic                             rd_dr,
  input  logic                             rd_dc,
  output logic [pool2_pkg::RD_ADDR_W-1:0]  rd_addr_c,
  output logic [pool2_pkg::WR_ADDR_W-1:0]  wr_addr_c,
  output logic                             last_window_c
);
  import pool2_pkg::*;

  localparam logic [PROW_W-1:0] PMAX = PROW_W'(POOL_EDGE - 1);
  localparam logic [CH_W-1:0]   CMAX = CH_W'(CHANNELS - 1);

  logic [CH_W-1:0]   r_ch;
  logic [PROW_W-1:0] r_prow;
  logic [PROW_W-1:0] r_pcol;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [PROW_W-1:0] w_prow_nxt;
  logic [PROW_W-1:0] w_pcol_nxt;
  logic [CH_W-1:0]   w_ch_la;
  logic [PROW_W-1:0] w_prow_la;
  logic [PROW_W-1:0] w_pcol_la;

  // Next window: pcol inner, prow middle, channel outer; channel wraps after the last map.
  always_comb begin
    w_pcol_nxt = r_pcol + PROW_W'(1);
    w_prow_nxt = r_prow;
    w_ch_nxt   = r_ch;
    if (r_pcol == PMAX) begin
      w_pcol_nxt = '0;
      w_prow_nxt = r_prow + PROW_W'(1);
      if (r_prow == PMAX) begin
        w_prow_nxt = '0;
        w_ch_nxt   = (r_ch == CMAX) ? '0 : r_ch + CH_W'(1);
      end
    end
  end

  // Address composition; row = {prow, dr} and col = {pcol, dc} since r = 2*prow, c = 2*pcol.
  always_comb begin
    w_ch_la       = advance ? w_ch_nxt   : r_ch;
    w_prow_la     = advance ? w_prow_nxt : r_prow;
    w_pcol_la     = advance ? w_pcol_nxt : r_pcol;
    rd_addr_c     = {w_ch_la, w_prow_la, rd_dr, w_pcol_la, rd_dc};
    wr_addr_c     = {r_ch, r_prow, r_pcol};
    last_window_c = (r_ch == CMAX) && (r_prow == PMAX) && (r_pcol == PMAX);
  end

  // Window counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch   <= '0;
      r_prow <= '0;
      r_pcol <= '0;
    end else if (advance) begin
      r_ch   <= w_ch_nxt;
      r_prow <= w_prow_nxt;
      r_pcol <= w_pcol_nxt;
    end
  end

endmodule

// File: rtl/pool2_maxpool.sv
// Pool-2 stage: 2x2 non-overlapping max pooling of the conv2 maps into the pool-2 memory.
// Optional build macro POOL2_RELU_EN: clamps negative window maxima to zero (fused ReLU).
// wr_data is combinational in WR because the last window sample arrives that cycle.
module pool2_maxpool #(
  parameter int unsigned DATA_W   = pool2_pkg::DATA_W,
  parameter int unsigned CHANNELS = pool2_pkg::CHANNELS,
  parameter int unsigned IMG_W    = pool2_pkg::IMG_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [pool2_pkg::RD_ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]                rd_data,
  output logic [pool2_pkg::WR_ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             wr_en,
  output logic                             busy,
  output logic                             done
);
  import pool2_pkg::*;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [DATA_W-1:0]  r_max;
  logic signed [DATA_W-1:0]  w_max_next;
  logic signed [DATA_W-1:0]  w_rd;
  logic signed [DATA_W-1:0]  w_win_max;
  logic signed [DATA_W-1:0]  w_result;
  logic                      w_advance;
  logic                      w_last;
  logic                      w_dr;
  logic                      w_dc;
  logic                      w_rd_load;
  logic [RD_ADDR_W-1:0]      w_rd_addr;
  logic [WR_ADDR_W-1:0]      w_wr_addr;
  logic                      w_wr_en_next;
  logic                      w_busy_next;
  logic                      w_done_next;

  pool2_addr_gen #(
    .CHANNELS  (CHANNELS),
    .POOL_EDGE (IMG_W / 2)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .advance       (w_advance),
    .rd_dr         (w_dr),
    .rd_dc         (w_dc),
    .rd_addr_c     (w_rd_addr),
    .wr_addr_c     (w_wr_addr),
    .last_window_c (w_last)
  );

  assign w_rd = $signed(rd_data);

  // Next state, read offsets for the state being entered, and next registered outputs.
  always_comb begin
    w_next     = r_state;
    w_advance  = 1'b0;
    w_dr       = 1'b0;
    w_dc       = 1'b0;
    w_rd_load  = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = R0;
      R0:      w_next = R1;
      R1:      w_next = R2;
      R2:      w_next = R3;
      R3:      w_next = WR;
      WR: begin
        w_advance = 1'b1;
        w_next    = w_last ? FIN : R0;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    case (w_next)
      R0:      w_rd_load = 1'b1;
      R1: begin w_rd_load = 1'b1; w_dc = 1'b1; end
      R2: begin w_rd_load = 1'b1; w_dr = 1'b1; end
      R3: begin w_rd_load = 1'b1; w_dr = 1'b1; w_dc = 1'b1; end
      default: w_rd_load = 1'b0;
    endcase
    w_busy_next  = (w_next == R0) || (w_next == R1) || (w_next == R2) ||
                   (w_next == R3) || (w_next == WR);
    w_wr_en_next = (w_next == WR);
    w_done_next  = (w_next == FIN) || (done && (w_next == IDLE));
  end

  // Running maximum over the samples returned in R1..R3.
  always_comb begin
    w_max_next = r_max;
    case (r_state)
      R1:      w_max_next = w_rd;
      R2, R3:  w_max_next = (w_rd > r_max) ? w_rd : r_max;
      default: w_max_next = r_max;
    endcase
  end

  // Window result from the running max and the final sample, driven only in WR.
  always_comb begin
    w_win_max = (w_rd > r_max) ? w_rd : r_max;
`ifdef POOL2_RELU_EN
    w_result  = w_win_max[DATA_W-1] ? '0 : w_win_max;
`else
    w_result  = w_win_max;
`endif
    wr_data   = (r_state == WR) ? w_result : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max   <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_max   <= w_max_next;
      if (w_rd_load)      rd_addr <= w_rd_addr;
      if (w_next == WR)   wr_addr <= w_wr_addr;
      wr_en   <= w_wr_en_next;
      busy    <= w_busy_next;
      done    <= w_done_next;
    end
  end

endmodule
